// File: rtl/cacheline_arbiter.sv
// Shares the single physical-memory cacheline port between the L1 I-cache and D-cache, one transfer at a time.
// Define CACHELINE_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default gives the D-cache every tie.
module cacheline_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_addr,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_addr,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_addr,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic                  write_q;
   logic [31:0]           icache_grants;
   logic [31:0]           dcache_grants;
   logic                  req_i;
   logic                  req_d;
   logic                  grant_i;
   logic                  grant_d;

   assign req_i = icache_read;
   assign req_d = dcache_read | dcache_write;

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
   // last_grant_d is set when the D-cache won the most recent grant
   logic last_grant_d;
   assign grant_i = req_i & (~req_d | last_grant_d);
`else
   assign grant_i = req_i & ~req_d;
`endif
   assign grant_d = req_d & ~grant_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         write_q       <= 1'b0;
         icache_grants <= '0;
         dcache_grants <= '0;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
         last_grant_d  <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_i) begin
                  state         <= SERVE_I;
                  addr_q        <= icache_addr;
                  write_q       <= 1'b0;
                  icache_grants <= icache_grants + 32'd1;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
                  last_grant_d  <= 1'b0;
`endif
               end else if (grant_d) begin
                  state         <= SERVE_D;
                  addr_q        <= dcache_addr;
                  write_q       <= dcache_write;
                  dcache_grants <= dcache_grants + 32'd1;
                  if (dcache_write) begin
                     wdata_q <= dcache_wdata;
                  end
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
                  last_grant_d  <= 1'b1;
`endif
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory side is driven purely from the latched transaction, so requester changes mid-serve are invisible
   assign pmem_read    = (state == SERVE_I) | ((state == SERVE_D) & ~write_q);
   assign pmem_write   = (state == SERVE_D) & write_q;
   assign pmem_addr    = (state == IDLE) ? '0 : addr_q;
   assign pmem_wdata   = pmem_write ? wdata_q : '0;

   assign icache_resp  = (state == SERVE_I) & pmem_resp;
   assign dcache_resp  = (state == SERVE_D) & pmem_resp;
   assign icache_rdata = icache_resp ? pmem_rdata : '0;
   assign dcache_rdata = dcache_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed vector table, contention/reset sequences, random vs. model.
module tb_cacheline_arbiter;

   localparam logic [255:0] Z   = '0;
   localparam logic [255:0] A5  = {32{8'hA5}};
   localparam logic [255:0] R5A = {32{8'h5A}};
   localparam logic [255:0] W1  = {16{16'h1234}};
   localparam logic [255:0] W2  = {8{32'hDEADBEEF}};
   localparam logic [255:0] W3  = {8{32'h0BADF00D}};

   logic         clk;
   logic         rst;
   logic         icache_read;
   logic [31:0]  icache_addr;
   logic [255:0] icache_rdata;
   logic         icache_resp;
   logic         dcache_read;
   logic         dcache_write;
   logic [31:0]  dcache_addr;
   logic [255:0] dcache_wdata;
   logic [255:0] dcache_rdata;
   logic         dcache_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_addr;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int n_compared = 0;
   int n_mismatched = 0;

   cacheline_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read), .icache_addr(icache_addr),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic         iread;
      logic [31:0]  iaddr;
      logic         dread;
      logic         dwrite;
      logic [31:0]  daddr;
      logic [255:0] dwdata;
      logic         presp;
      logic [255:0] prdata;
      logic         e_pread;
      logic         e_pwrite;
      logic [31:0]  e_paddr;
      logic [255:0] e_pwdata;
      logic         e_iresp;
      logic         e_dresp;
      logic [255:0] e_rdata;
   } vec_t;

   vec_t vecs[$];

   // Transaction-level reference: who owns the memory port and what was captured at grant time
   int          m_owner;
   logic [31:0] m_addr;
   bit          m_write;
   logic [255:0] m_wdata;
   bit          m_last_d;
   logic [31:0] m_igr;
   logic [31:0] m_dgr;

   task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      n_compared++;
      if (act != exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic iread, input logic [31:0] iaddr, input logic dread,
                          input logic dwrite, input logic [31:0] daddr, input logic [255:0] dwdata,
                          input logic presp, input logic [255:0] prdata, input logic e_pread,
                          input logic e_pwrite, input logic [31:0] e_paddr, input logic [255:0] e_pwdata,
                          input logic e_iresp, input logic e_dresp, input logic [255:0] e_rdata);
      vec_t v;
      v.iread = iread; v.iaddr = iaddr; v.dread = dread; v.dwrite = dwrite;
      v.daddr = daddr; v.dwdata = dwdata; v.presp = presp; v.prdata = prdata;
      v.e_pread = e_pread; v.e_pwrite = e_pwrite; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
      v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_rdata = e_rdata;
      vecs.push_back(v);
   endtask

   task automatic apply_stimulus(input vec_t v);
      icache_read  = v.iread;
      icache_addr  = v.iaddr;
      dcache_read  = v.dread;
      dcache_write = v.dwrite;
      dcache_addr  = v.daddr;
      dcache_wdata = v.dwdata;
      pmem_resp    = v.presp;
      pmem_rdata   = v.prdata;
   endtask

   task automatic clear_inputs();
      icache_read = 0; icache_addr = 0; dcache_read = 0; dcache_write = 0;
      dcache_addr = 0; dcache_wdata = 0; pmem_resp = 0; pmem_rdata = 0;
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   // Every task starts and ends just after a rising edge
   task automatic do_reset(input string tag);
      rst = 0;
      clear_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      check_output({tag, "_rst_pmem_read"}, pmem_read, 0);
      check_output({tag, "_rst_pmem_write"}, pmem_write, 0);
      check_output({tag, "_rst_pmem_addr"}, pmem_addr, 0);
      check_output({tag, "_rst_pmem_wdata"}, pmem_wdata, 0);
      check_output({tag, "_rst_icache_resp"}, icache_resp, 0);
      check_output({tag, "_rst_dcache_resp"}, dcache_resp, 0);
      check_output({tag, "_rst_icache_rdata"}, icache_rdata, 0);
      check_output({tag, "_rst_dcache_rdata"}, dcache_rdata, 0);
      check_output({tag, "_rst_icache_grants"}, dut.icache_grants, 0);
      check_output({tag, "_rst_dcache_grants"}, dut.dcache_grants, 0);
      @(posedge clk); #1;
      rst = 1;
   endtask

   task automatic run_table();
      add_vec(1, 32'h1000, 0, 0, 0, Z,  0, Z,   0, 0, 0,        Z,  0, 0, Z);
      for (int i = 0; i < 4; i++)
         add_vec(1, 32'h1000, 0, 0, 0, Z, 0, Z, 1, 0, 32'h1000, Z, 0, 0, Z);
      add_vec(1, 32'h1000, 0, 0, 0, Z,  1, A5,  1, 0, 32'h1000, Z,  1, 0, A5);
      add_vec(0, 0,        0, 0, 0, Z,  0, Z,   0, 0, 0,        Z,  0, 0, Z);
      add_vec(0, 0,        0, 0, 0, Z,  1, R5A, 0, 0, 0,        Z,  0, 0, Z);
      add_vec(0, 0,        0, 1, 32'h2040, W1, 0, Z, 0, 0, 0,   Z,  0, 0, Z);
      add_vec(0, 0,        0, 1, 32'h3000, W1, 0, Z, 0, 1, 32'h2040, W1, 0, 0, Z);
      add_vec(0, 0,        0, 1, 32'h3000, W2, 0, Z, 0, 1, 32'h2040, W1, 0, 0, Z);
      add_vec(0, 0,        0, 1, 32'h3000, W2, 1, A5, 0, 1, 32'h2040, W1, 0, 1, A5);
      add_vec(0, 0,        0, 0, 0, Z,  0, Z,   0, 0, 0,        Z,  0, 0, Z);
      add_vec(0, 0,        1, 0, 32'h4000, Z, 0, Z, 0, 0, 0,    Z,  0, 0, Z);
      add_vec(0, 0,        1, 0, 32'h4000, Z, 1, R5A, 1, 0, 32'h4000, Z, 0, 1, R5A);
      add_vec(0, 0,        0, 0, 0, Z,  0, Z,   0, 0, 0,        Z,  0, 0, Z);
      add_vec(0, 0,        1, 1, 32'h5000, W3, 0, Z, 0, 0, 0,   Z,  0, 0, Z);
      add_vec(0, 0,        1, 1, 32'h5000, W3, 1, A5, 0, 1, 32'h5000, W3, 0, 1, A5);
      add_vec(0, 0,        0, 0, 0, Z,  0, Z,   0, 0, 0,        Z,  0, 0, Z);
      foreach (vecs[k]) begin
         apply_stimulus(vecs[k]);
         @(negedge clk);
         check_output($sformatf("vec%0d_pmem_read", k), pmem_read, vecs[k].e_pread);
         check_output($sformatf("vec%0d_pmem_write", k), pmem_write, vecs[k].e_pwrite);
         check_output($sformatf("vec%0d_icache_resp", k), icache_resp, vecs[k].e_iresp);
         check_output($sformatf("vec%0d_dcache_resp", k), dcache_resp, vecs[k].e_dresp);
         if (vecs[k].e_pread || vecs[k].e_pwrite)
            check_output($sformatf("vec%0d_pmem_addr", k), pmem_addr, vecs[k].e_paddr);
         if (vecs[k].e_pwrite)
            check_output($sformatf("vec%0d_pmem_wdata", k), pmem_wdata, vecs[k].e_pwdata);
         if (vecs[k].e_iresp)
            check_output($sformatf("vec%0d_icache_rdata", k), icache_rdata, vecs[k].e_rdata);
         if (vecs[k].e_dresp)
            check_output($sformatf("vec%0d_dcache_rdata", k), dcache_rdata, vecs[k].e_rdata);
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   // Both caches want four lines each, re-requesting immediately; memory answers one cycle after the strobe
   task automatic contention_test();
      string order = "";
      string exp_order;
      int    i_left = 4;
      int    d_left = 4;
      int    cyc = 0;
      bit    busy = 0;
      bit    last_resp = 0;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
      exp_order = "IDIDIDID";
`else
      exp_order = "DDDDIIII";
`endif
      icache_read = 1; icache_addr = 32'h100;
      dcache_read = 1; dcache_addr = 32'h200;
      while ((i_left > 0 || d_left > 0) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (last_resp)
            check_output("turnaround_idle", {pmem_read, pmem_write}, 0);
         last_resp = 0;
         if ((pmem_read || pmem_write) && !busy) begin
            busy = 1;
            order = {order, (pmem_addr == 32'h100) ? "I" : "D"};
         end
         if (pmem_resp) begin
            if (icache_resp) i_left--;
            if (dcache_resp) d_left--;
            busy = 0;
            last_resp = 1;
         end
         @(posedge clk); #1;
         pmem_resp   = busy;
         pmem_rdata  = rand_line();
         icache_read = (i_left > 0);
         dcache_read = (d_left > 0);
      end
      check_output("contention_all_done", i_left + d_left, 0);
      check_str("contention_order", order, exp_order);
      clear_inputs();
   endtask

   task automatic reset_mid_test();
      dcache_write = 1; dcache_addr = 32'h6000; dcache_wdata = W1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check_output("rstmid_serving_write", pmem_write, 1);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      rst = 1; dcache_write = 0; pmem_resp = 1;
      @(negedge clk);
      check_output("rstmid_pmem_read", pmem_read, 0);
      check_output("rstmid_pmem_write", pmem_write, 0);
      check_output("rstmid_icache_resp", icache_resp, 0);
      check_output("rstmid_dcache_resp", dcache_resp, 0);
      check_output("rstmid_icache_grants", dut.icache_grants, 0);
      check_output("rstmid_dcache_grants", dut.dcache_grants, 0);
      @(posedge clk); #1;
      pmem_resp = 0; icache_read = 1; icache_addr = 32'h7000;
      @(negedge clk);
      check_output("rstmid_idle_before_grant", pmem_read, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_output("rstmid_regrant_read", pmem_read, 1);
      check_output("rstmid_regrant_addr", pmem_addr, 32'h7000);
      @(posedge clk); #1;
      pmem_resp = 1; pmem_rdata = A5;
      @(negedge clk);
      check_output("rstmid_regrant_resp", icache_resp, 1);
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic model_reset();
      m_owner = 0; m_addr = 0; m_write = 0; m_wdata = 0;
      m_last_d = 1; m_igr = 0; m_dgr = 0;
   endtask

   // Advances the reference by one rising edge using the inputs held across that edge
   task automatic model_step(output bit i_done, output bit d_done);
      int win;
      i_done = 0;
      d_done = 0;
      if (!rst) begin
         model_reset();
      end else if (m_owner == 0) begin
         win = 0;
         if (icache_read && (dcache_read || dcache_write)) begin
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
            win = m_last_d ? 1 : 2;
`else
            win = 2;
`endif
         end else if (icache_read) win = 1;
         else if (dcache_read || dcache_write) win = 2;
         if (win == 1) begin
            m_owner = 1; m_addr = icache_addr; m_write = 0; m_last_d = 0; m_igr = m_igr + 1;
         end else if (win == 2) begin
            m_owner = 2; m_addr = dcache_addr; m_write = dcache_write; m_last_d = 1; m_dgr = m_dgr + 1;
            if (dcache_write) m_wdata = dcache_wdata;
         end
      end else if (pmem_resp) begin
         i_done = (m_owner == 1);
         d_done = (m_owner == 2);
         m_owner = 0;
      end
   endtask

   task automatic random_test(input int cycles);
      bit i_done, d_done;
      bit e_pr, e_pw, e_ir, e_dr;
      model_reset();
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         e_pr = (m_owner == 1) || (m_owner == 2 && !m_write);
         e_pw = (m_owner == 2) && m_write;
         e_ir = (m_owner == 1) && pmem_resp;
         e_dr = (m_owner == 2) && pmem_resp;
         check_output("rnd_pmem_read", pmem_read, e_pr);
         check_output("rnd_pmem_write", pmem_write, e_pw);
         check_output("rnd_icache_resp", icache_resp, e_ir);
         check_output("rnd_dcache_resp", dcache_resp, e_dr);
         if (e_pr || e_pw) check_output("rnd_pmem_addr", pmem_addr, m_addr);
         if (e_pw) check_output("rnd_pmem_wdata", pmem_wdata, m_wdata);
         if (e_ir) check_output("rnd_icache_rdata", icache_rdata, pmem_rdata);
         if (e_dr) check_output("rnd_dcache_rdata", dcache_rdata, pmem_rdata);
         @(posedge clk); #1;
         model_step(i_done, d_done);
         rst = ($urandom_range(0, 299) != 0);
         if (i_done || !icache_read) begin
            icache_read = ($urandom_range(0, 2) == 0);
            icache_addr = $urandom() & ~32'h1F;
         end else if (m_owner == 1) begin
            icache_addr = $urandom() & ~32'h1F;
         end
         if (d_done || !(dcache_read || dcache_write)) begin
            case ($urandom_range(0, 5))
               0: begin dcache_read = 1; dcache_write = 0; end
               1: begin dcache_read = 0; dcache_write = 1; end
               2: begin dcache_read = 1; dcache_write = 1; end
               default: begin dcache_read = 0; dcache_write = 0; end
            endcase
            dcache_addr  = $urandom() & ~32'h1F;
            dcache_wdata = rand_line();
         end else if (m_owner == 2) begin
            dcache_addr  = $urandom() & ~32'h1F;
            dcache_wdata = rand_line();
         end
         pmem_resp  = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
         pmem_rdata = rand_line();
      end
      @(negedge clk);
      check_output("rnd_icache_grants", dut.icache_grants, m_igr);
      check_output("rnd_dcache_grants", dut.dcache_grants, m_dgr);
      @(posedge clk); #1;
      rst = 1;
      clear_inputs();
   endtask

   initial begin
      rst = 0;
      clear_inputs();
      @(posedge clk); #1;
      do_reset("init");
      $display("[TB] directed vector table");
      run_table();
      do_reset("contention");
      $display("[TB] continuous contention");
      contention_test();
      $display("[TB] reset during a D write-back");
      reset_mid_test();
      do_reset("random");
      $display("[TB] randomized traffic against reference model");
      random_test(2000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
